// File: rtl/mult_div_alu_if.sv
// mult_div_alu_if: operand/command and result bundle for the EX-stage ALU.
// The control side (master) drives the request; the ALU (slave) returns results.
interface mult_div_alu_if #(
   parameter int WIDTH = 32
);
   logic             Start;
   logic [3:0]       ALUControl;
   logic [WIDTH-1:0] Operand1;
   logic [WIDTH-1:0] Operand2;
   logic [WIDTH-1:0] ALUResult;
   logic             Zero;
   logic [WIDTH-1:0] Hi;
   logic [WIDTH-1:0] Lo;
   logic             Busy;
   logic             Done;
   logic             DivByZero;

   modport master (
      output Start, ALUControl, Operand1, Operand2,
      input  ALUResult, Zero, Hi, Lo, Busy, Done, DivByZero
   );

   modport slave (
      input  Start, ALUControl, Operand1, Operand2,
      output ALUResult, Zero, Hi, Lo, Busy, Done, DivByZero
   );
endinterface

// File: rtl/mult_div_alu.sv
// mult_div_alu: registered EX-stage ALU with SLT/SLTU, HI/LO multiply/divide
// and MFHI/MFLO. Multiply (shift-add) and divide (restoring) iterate one bit
// per cycle behind a Start/Busy/Done handshake.
// Optional macro MULDIV_FAST_MUL_EN: MULT/MULTU finish in one cycle through a
// combinational multiplier; divide stays iterative.
module mult_div_alu #(
   parameter int WIDTH = 32
) (
   input  logic          clk,
   input  logic          reset,
   mult_div_alu_if.slave bus
);
   localparam int            CW       = $clog2(WIDTH);
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   localparam logic [3:0] OP_AND   = 4'b0000;
   localparam logic [3:0] OP_OR    = 4'b0001;
   localparam logic [3:0] OP_ADD   = 4'b0010;
   localparam logic [3:0] OP_SUB   = 4'b0011;
   localparam logic [3:0] OP_SLT   = 4'b0100;
   localparam logic [3:0] OP_SLTU  = 4'b0101;
   localparam logic [3:0] OP_MULTU = 4'b1000;
   localparam logic [3:0] OP_MULT  = 4'b1001;
   localparam logic [3:0] OP_DIVU  = 4'b1010;
   localparam logic [3:0] OP_DIV   = 4'b1011;
   localparam logic [3:0] OP_MFHI  = 4'b1100;
   localparam logic [3:0] OP_MFLO  = 4'b1101;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MUL  = 2'd1,
      S_DIV  = 2'd2,
      S_FIN  = 2'd3
   } state_t;

   // Two's-complement negate, WIDTH bits.
   function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v);
      return ~v + {{(WIDTH-1){1'b0}}, 1'b1};
   endfunction

   // Two's-complement negate, 2*WIDTH bits.
   function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] v);
      return ~v + {{(2*WIDTH-1){1'b0}}, 1'b1};
   endfunction

   // Magnitude of v when it is to be treated as negative; the most-negative
   // value maps onto 2^(WIDTH-1), which still fits as an unsigned magnitude.
   function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic is_neg);
      logic [WIDTH-1:0] m;
      if (is_neg) begin
         m = neg_w(v);
      end else begin
         m = v;
      end
      return m;
   endfunction

   state_t             state_q, state_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [2*WIDTH-1:0] acc_q, acc_d;       // multiply: {partial product, remaining multiplier}
   logic [WIDTH-1:0]   rem_q, rem_d;       // divide: partial remainder
   logic [WIDTH-1:0]   quo_q, quo_d;       // divide: dividend bits shifting out, quotient shifting in
   logic [WIDTH-1:0]   b_q, b_d;           // multiplicand / divisor magnitude
   logic               neg_q, neg_d;       // negate product / quotient at the end
   logic               neg_rem_q, neg_rem_d;
   logic [WIDTH-1:0]   result_q, result_d;
   logic               zero_q, zero_d;
   logic [WIDTH-1:0]   hi_q, hi_d;
   logic [WIDTH-1:0]   lo_q, lo_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic               dbz_q, dbz_d;

   logic               a_neg_s, b_neg_s;
   logic [WIDTH-1:0]   mag_a_s, mag_b_s;
   logic [WIDTH-1:0]   alu_s;
   logic [WIDTH:0]     mul_sum_s;
   logic [2*WIDTH-1:0] mul_next_s, mul_fix_s;
   logic [WIDTH:0]     rem_sh_s;
   logic               rem_ge_s;
   logic [WIDTH-1:0]   rem_next_s, quo_next_s, rem_fix_s, quo_fix_s;
`ifdef MULDIV_FAST_MUL_EN
   logic [2*WIDTH-1:0] fast_prod_s, fast_fix_s;
`endif

   // Operand magnitudes and the single-cycle result for the current request.
   always_comb begin
      a_neg_s = bus.ALUControl[0] & bus.Operand1[WIDTH-1];
      b_neg_s = bus.ALUControl[0] & bus.Operand2[WIDTH-1];
      mag_a_s = magnitude(bus.Operand1, a_neg_s);
      mag_b_s = magnitude(bus.Operand2, b_neg_s);
      case (bus.ALUControl)
         OP_AND:  alu_s = bus.Operand1 & bus.Operand2;
         OP_OR:   alu_s = bus.Operand1 | bus.Operand2;
         OP_ADD:  alu_s = bus.Operand1 + bus.Operand2;
         OP_SUB:  alu_s = bus.Operand1 - bus.Operand2;
         OP_SLT:  alu_s = {{(WIDTH-1){1'b0}}, ($signed(bus.Operand1) < $signed(bus.Operand2))};
         OP_SLTU: alu_s = {{(WIDTH-1){1'b0}}, (bus.Operand1 < bus.Operand2)};
         OP_MFHI: alu_s = hi_q;
         OP_MFLO: alu_s = lo_q;
         default: alu_s = {WIDTH{1'b0}};
      endcase
   end

   // One shift-add multiply step and one restoring divide step, plus sign fix-up.
   always_comb begin
      mul_sum_s  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, b_q} : {(WIDTH+1){1'b0}});
      mul_next_s = {mul_sum_s, acc_q[WIDTH-1:1]};
      if (neg_q) begin
         mul_fix_s = neg_2w(mul_next_s);
      end else begin
         mul_fix_s = mul_next_s;
      end
      rem_sh_s   = {rem_q, quo_q[WIDTH-1]};
      rem_ge_s   = (rem_sh_s >= {1'b0, b_q});
      if (rem_ge_s) begin
         rem_next_s = rem_sh_s[WIDTH-1:0] - b_q;
      end else begin
         rem_next_s = rem_sh_s[WIDTH-1:0];
      end
      quo_next_s = {quo_q[WIDTH-2:0], rem_ge_s};
      if (neg_q) begin
         quo_fix_s = neg_w(quo_next_s);
      end else begin
         quo_fix_s = quo_next_s;
      end
      if (neg_rem_q) begin
         rem_fix_s = neg_w(rem_next_s);
      end else begin
         rem_fix_s = rem_next_s;
      end
   end

`ifdef MULDIV_FAST_MUL_EN
   // Full-width combinational product of the operand magnitudes, sign-corrected.
   always_comb begin
      fast_prod_s = {{WIDTH{1'b0}}, mag_a_s} * {{WIDTH{1'b0}}, mag_b_s};
      if (a_neg_s ^ b_neg_s) begin
         fast_fix_s = neg_2w(fast_prod_s);
      end else begin
         fast_fix_s = fast_prod_s;
      end
   end
`endif

   // Next-state and next-output logic of the IDLE/MUL/DIV/FIN controller.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      acc_d     = acc_q;
      rem_d     = rem_q;
      quo_d     = quo_q;
      b_d       = b_q;
      neg_d     = neg_q;
      neg_rem_d = neg_rem_q;
      result_d  = result_q;
      zero_d    = zero_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      busy_d    = 1'b0;
      done_d    = 1'b0;
      dbz_d     = dbz_q;
      case (state_q)
         S_MUL: begin
            acc_d = mul_next_s;
            cnt_d = cnt_q + CNT_ONE;
            if (cnt_q == CNT_LAST) begin
               hi_d    = mul_fix_s[2*WIDTH-1:WIDTH];
               lo_d    = mul_fix_s[WIDTH-1:0];
               zero_d  = (mul_fix_s[WIDTH-1:0] == {WIDTH{1'b0}});
               done_d  = 1'b1;
               state_d = S_FIN;
            end else begin
               busy_d  = 1'b1;
            end
         end
         S_DIV: begin
            rem_d = rem_next_s;
            quo_d = quo_next_s;
            cnt_d = cnt_q + CNT_ONE;
            if (cnt_q == CNT_LAST) begin
               hi_d    = rem_fix_s;
               lo_d    = quo_fix_s;
               zero_d  = (quo_fix_s == {WIDTH{1'b0}});
               done_d  = 1'b1;
               state_d = S_FIN;
            end else begin
               busy_d  = 1'b1;
            end
         end
         S_IDLE, S_FIN: begin
            // FIN is the Done cycle; Busy is already low so a new Start is taken.
            state_d = S_IDLE;
            if (bus.Start) begin
               dbz_d = 1'b0;
               case (bus.ALUControl)
                  OP_MULTU, OP_MULT: begin
`ifdef MULDIV_FAST_MUL_EN
                     hi_d   = fast_fix_s[2*WIDTH-1:WIDTH];
                     lo_d   = fast_fix_s[WIDTH-1:0];
                     zero_d = (fast_fix_s[WIDTH-1:0] == {WIDTH{1'b0}});
                     done_d = 1'b1;
`else
                     state_d = S_MUL;
                     busy_d  = 1'b1;
                     acc_d   = {{WIDTH{1'b0}}, mag_a_s};
                     b_d     = mag_b_s;
                     cnt_d   = {CW{1'b0}};
                     neg_d   = a_neg_s ^ b_neg_s;
`endif
                  end
                  OP_DIVU, OP_DIV: begin
                     if (bus.Operand2 == {WIDTH{1'b0}}) begin
                        hi_d   = bus.Operand1;
                        lo_d   = {WIDTH{1'b1}};
                        zero_d = 1'b0;
                        dbz_d  = 1'b1;
                        done_d = 1'b1;
                     end else begin
                        state_d   = S_DIV;
                        busy_d    = 1'b1;
                        rem_d     = {WIDTH{1'b0}};
                        quo_d     = mag_a_s;
                        b_d       = mag_b_s;
                        cnt_d     = {CW{1'b0}};
                        neg_d     = a_neg_s ^ b_neg_s;
                        neg_rem_d = a_neg_s;
                     end
                  end
                  default: begin
                     result_d = alu_s;
                     zero_d   = (alu_s == {WIDTH{1'b0}});
                     done_d   = 1'b1;
                  end
               endcase
            end else begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State and output registers; reset aborts any operation in flight.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= S_IDLE;
         cnt_q     <= {CW{1'b0}};
         acc_q     <= {(2*WIDTH){1'b0}};
         rem_q     <= {WIDTH{1'b0}};
         quo_q     <= {WIDTH{1'b0}};
         b_q       <= {WIDTH{1'b0}};
         neg_q     <= 1'b0;
         neg_rem_q <= 1'b0;
         result_q  <= {WIDTH{1'b0}};
         zero_q    <= 1'b0;
         hi_q      <= {WIDTH{1'b0}};
         lo_q      <= {WIDTH{1'b0}};
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         dbz_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         acc_q     <= acc_d;
         rem_q     <= rem_d;
         quo_q     <= quo_d;
         b_q       <= b_d;
         neg_q     <= neg_d;
         neg_rem_q <= neg_rem_d;
         result_q  <= result_d;
         zero_q    <= zero_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         dbz_q     <= dbz_d;
      end
   end

   assign bus.ALUResult = result_q;
   assign bus.Zero      = zero_q;
   assign bus.Hi        = hi_q;
   assign bus.Lo        = lo_q;
   assign bus.Busy      = busy_q;
   assign bus.Done      = done_q;
   assign bus.DivByZero = dbz_q;
endmodule

// File: tb/tb_mult_div_alu.sv
// tb_mult_div_alu: directed and randomized checks of mult_div_alu against a
// cycle-level behavioural model built from plain 64-bit arithmetic.
module tb_mult_div_alu;
   localparam int W = 32;
`ifdef MULDIV_FAST_MUL_EN
   localparam int MUL_WAIT = 0;
`else
   localparam int MUL_WAIT = W;
`endif

   logic clk = 1'b0;
   logic reset;
   int   tests = 0;
   int   fails = 0;

   mult_div_alu_if #(.WIDTH(W)) bus ();
   mult_div_alu #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(bus));

   always #5 clk = ~clk;

   typedef struct packed {
      logic [W-1:0] res;
      logic         upd_res;
      logic         zero;
      logic         upd_hilo;
      logic [W-1:0] hi;
      logic [W-1:0] lo;
      logic         dbz;
      int           lat;
   } exp_t;

   // Expected outcome of one accepted request, from the instruction semantics.
   function automatic exp_t model_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                     input logic [W-1:0] hi, input logic [W-1:0] lo);
      exp_t e;
      longint sa, sb;
      longint unsigned up;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      e = '0;
      e.upd_res = 1'b1;
      case (op)
         4'd0:  e.res = a & b;
         4'd1:  e.res = a | b;
         4'd2:  e.res = a + b;
         4'd3:  e.res = a - b;
         4'd4:  e.res = (sa < sb) ? 32'd1 : 32'd0;
         4'd5:  e.res = (a < b) ? 32'd1 : 32'd0;
         4'd12: e.res = hi;
         4'd13: e.res = lo;
         4'd8, 4'd9: begin
            e.upd_res = 1'b0;
            e.upd_hilo = 1'b1;
            if (op == 4'd9) up = $unsigned(sa * sb);
            else up = {32'd0, a} * {32'd0, b};
            e.hi  = up[63:32];
            e.lo  = up[31:0];
            e.lat = MUL_WAIT;
         end
         4'd10, 4'd11: begin
            e.upd_res = 1'b0;
            e.upd_hilo = 1'b1;
            if (b == 32'd0) begin
               e.hi = a;
               e.lo = 32'hFFFF_FFFF;
               e.dbz = 1'b1;
            end else if (op == 4'd11) begin
               e.lo  = 32'(sa / sb);
               e.hi  = 32'(sa % sb);
               e.lat = W;
            end else begin
               e.lo  = a / b;
               e.hi  = a % b;
               e.lat = W;
            end
         end
         default: e.res = 32'd0;
      endcase
      e.zero = e.upd_res ? (e.res == 32'd0) : (e.lo == 32'd0);
      return e;
   endfunction

   // Model state: what the ALU's visible outputs must be after each edge.
   logic [W-1:0] m_res, m_hi, m_lo, p_hi, p_lo;
   logic         m_zero, m_done, m_dbz;
   int           busy_cnt = 0;
   exp_t         e_s;

   always_comb e_s = model_op(bus.ALUControl, bus.Operand1, bus.Operand2, m_hi, m_lo);

   // Advance the model on each rising edge.
   always @(posedge clk) begin
      if (reset) begin
         m_res <= '0; m_hi <= '0; m_lo <= '0; m_zero <= 1'b0;
         m_done <= 1'b0; m_dbz <= 1'b0; busy_cnt <= 0;
      end else if (busy_cnt > 0) begin
         busy_cnt <= busy_cnt - 1;
         if (busy_cnt == 1) begin
            m_hi <= p_hi; m_lo <= p_lo; m_zero <= (p_lo == 32'd0); m_done <= 1'b1;
         end else begin
            m_done <= 1'b0;
         end
      end else if (bus.Start) begin
         m_dbz <= e_s.dbz;
         if (e_s.lat == 0) begin
            m_done <= 1'b1;
            m_zero <= e_s.zero;
            if (e_s.upd_res) m_res <= e_s.res;
            if (e_s.upd_hilo) begin m_hi <= e_s.hi; m_lo <= e_s.lo; end
         end else begin
            m_done <= 1'b0;
            busy_cnt <= e_s.lat;
            p_hi <= e_s.hi;
            p_lo <= e_s.lo;
         end
      end else begin
         m_done <= 1'b0;
      end
   end

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: actual %h required %h", name, act, exp);
      end
   endtask

   // Compare every DUT output against the model on each falling edge.
   always @(negedge clk) begin
      chk("ALUResult", bus.ALUResult, m_res);
      chk("Zero", bus.Zero, m_zero);
      chk("Hi", bus.Hi, m_hi);
      chk("Lo", bus.Lo, m_lo);
      chk("Busy", bus.Busy, busy_cnt != 0);
      chk("Done", bus.Done, m_done);
      chk("DivByZero", bus.DivByZero, m_dbz);
   end

   // Issue one request and wait (bounded) for Done; checks the cycle count.
   task automatic do_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input int exp_wait);
      int n;
      bus.Start = 1'b1; bus.ALUControl = op; bus.Operand1 = a; bus.Operand2 = b;
      @(negedge clk);
      bus.Start = 1'b0;
      n = 0;
      while (!bus.Done && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk("done_wait", n, exp_wait);
   endtask

   function automatic logic [W-1:0] pick();
      int unsigned k;
      logic [W-1:0] v;
      k = $urandom_range(0, 7);
      case (k)
         0: v = 32'd0;
         1: v = 32'hFFFF_FFFF;
         2: v = 32'h8000_0000;
         3: v = 32'd1;
         4: v = 32'($urandom_range(0, 15));
         default: v = $urandom;
      endcase
      return v;
   endfunction

   initial begin
      int n;
      int dn;
      logic [3:0] ops [14];
      ops = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd8, 4'd9, 4'd10, 4'd11, 4'd12, 4'd13, 4'd6, 4'd15};

      reset = 1'b1;
      bus.Start = 1'b1; bus.ALUControl = 4'd2; bus.Operand1 = 32'd5; bus.Operand2 = 32'd6;
      repeat (2) @(negedge clk);
      chk("rst_res", bus.ALUResult, 32'd0);
      chk("rst_hi", bus.Hi, 32'd0);
      chk("rst_lo", bus.Lo, 32'd0);
      chk("rst_flags", {bus.Zero, bus.Busy, bus.Done, bus.DivByZero}, 32'd0);
      reset = 1'b0;
      bus.Start = 1'b0;
      @(negedge clk);

      do_op(4'd2, 32'd85, 32'd16554, 0);
      chk("add", bus.ALUResult, 32'd16639);
      chk("add_zero", bus.Zero, 32'd0);
      do_op(4'd3, 32'd85, 32'd85, 0);
      chk("sub_eq", bus.ALUResult, 32'd0);
      chk("sub_zero", bus.Zero, 32'd1);
      do_op(4'd3, 32'd0, 32'd1, 0);
      chk("sub_wrap", bus.ALUResult, 32'hFFFF_FFFF);
      do_op(4'd4, 32'hFFFF_FFFF, 32'd1, 0);
      chk("slt", bus.ALUResult, 32'd1);
      do_op(4'd5, 32'hFFFF_FFFF, 32'd1, 0);
      chk("sltu", bus.ALUResult, 32'd0);
      do_op(4'd9, 32'hFFFF_FFFD, 32'd7, MUL_WAIT);
      chk("mult_hi", bus.Hi, 32'hFFFF_FFFF);
      chk("mult_lo", bus.Lo, 32'hFFFF_FFEB);
      do_op(4'd8, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MUL_WAIT);
      chk("multu_hi", bus.Hi, 32'hFFFF_FFFE);
      chk("multu_lo", bus.Lo, 32'h0000_0001);
      do_op(4'd13, 32'd0, 32'd0, 0);
      chk("mflo", bus.ALUResult, 32'h0000_0001);
      do_op(4'd11, 32'hFFFF_FFF9, 32'd2, W);
      chk("div_lo", bus.Lo, 32'hFFFF_FFFD);
      chk("div_hi", bus.Hi, 32'hFFFF_FFFF);
      do_op(4'd10, 32'd100, 32'd7, W);
      chk("divu_lo", bus.Lo, 32'd14);
      chk("divu_hi", bus.Hi, 32'd2);
      do_op(4'd11, 32'h8000_0000, 32'hFFFF_FFFF, W);
      chk("divmin_lo", bus.Lo, 32'h8000_0000);
      chk("divmin_hi", bus.Hi, 32'd0);
      do_op(4'd10, 32'd5, 32'd0, 0);
      chk("dbz_flag", bus.DivByZero, 32'd1);
      chk("dbz_hi", bus.Hi, 32'd5);
      chk("dbz_lo", bus.Lo, 32'hFFFF_FFFF);
      do_op(4'd2, 32'd2, 32'd3, 0);
      chk("dbz_clear", bus.DivByZero, 32'd0);
      chk("add2", bus.ALUResult, 32'd5);

      // Start during an active divide must be ignored.
      bus.Start = 1'b1; bus.ALUControl = 4'd11; bus.Operand1 = 32'hFFFF_FFF9; bus.Operand2 = 32'd2;
      @(negedge clk);
      bus.Start = 1'b0;
      repeat (4) @(negedge clk);
      bus.Start = 1'b1; bus.ALUControl = 4'd2; bus.Operand1 = 32'd100; bus.Operand2 = 32'd200;
      @(negedge clk);
      bus.Start = 1'b0; bus.ALUControl = 4'd0; bus.Operand1 = $urandom; bus.Operand2 = $urandom;
      n = 0;
      while (!bus.Done && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk("ign_wait", n, W - 5);
      chk("ign_lo", bus.Lo, 32'hFFFF_FFFD);
      chk("ign_hi", bus.Hi, 32'hFFFF_FFFF);
      chk("ign_res", bus.ALUResult, 32'd5);

      // Reset in the middle of a divide aborts it.
      bus.Start = 1'b1; bus.ALUControl = 4'd10; bus.Operand1 = 32'd100; bus.Operand2 = 32'd7;
      @(negedge clk);
      bus.Start = 1'b0;
      repeat (9) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("abort_busy", bus.Busy, 32'd0);
      chk("abort_hi", bus.Hi, 32'd0);
      chk("abort_lo", bus.Lo, 32'd0);
      dn = 0;
      repeat (40) begin
         @(negedge clk);
         if (bus.Done) dn++;
      end
      chk("abort_no_done", dn, 32'd0);

      // Random traffic, including Starts while busy and occasional resets.
      for (int i = 0; i < 3000; i++) begin
         bus.Start = ($urandom_range(0, 2) != 0);
         bus.ALUControl = ops[$urandom_range(0, 13)];
         bus.Operand1 = pick();
         bus.Operand2 = pick();
         reset = ($urandom_range(0, 399) == 0);
         @(negedge clk);
      end
      reset = 1'b0;
      bus.Start = 1'b0;
      repeat (2) @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/mult_div_alu.md
Name: mult_div_alu

Overview:
- Parametrised, registered successor to the single-cycle 2-bit-control ALU in the 32-bit MIPS datapath.
- Adds SLT/SLTU, signed and unsigned multiply and divide into HI/LO registers, and MFHI/MFLO readback.
- Multiply and divide are iterative, one bit per cycle, with a Start/Busy/Done handshake so the control unit can stall the pipeline.
- Sits in the EX stage in place of the combinational ALU.

Parameters:
WIDTH, 32, operand/result/HI/LO width (even, >=4)

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  synchronous, active-high; clears all state
Start  input  1  request; sampled only when Busy=0
ALUControl  input  4  operation select, latched with Start
Operand1  input  WIDTH  A operand / dividend, latched with Start
Operand2  input  WIDTH  B operand / divisor, latched with Start
ALUResult  output  WIDTH  registered result of single-cycle ops
Zero  output  1  registered zero flag
Hi  output  WIDTH  HI register (product upper / remainder)
Lo  output  WIDTH  LO register (product lower / quotient)
Busy  output  1  iterative op in progress
Done  output  1  one-cycle completion pulse
DivByZero  output  1  last accepted divide had Operand2=0

Behaviour:
- Reset (synchronous, active-high) clears ALUResult, Zero, Hi, Lo, Busy, Done and DivByZero to 0, and the FSM to IDLE.
  - Reset wins over a simultaneous Start.
  - Reset mid-operation aborts the operation: no Done, and Hi/Lo are cleared.
- ALUControl encoding:
  - 0000 AND; 0001 OR; 0010 ADD; 0011 SUB (both mod 2^WIDTH, no overflow trap).
  - 0100 SLT (signed), 0101 SLTU. Result is 1 or 0, zero-extended.
  - 1000 MULTU; 1001 MULT; 1010 DIVU; 1011 DIV.
  - 1100 MFHI (ALUResult=Hi); 1101 MFLO (ALUResult=Lo).
  - Any other code: ALUResult=0, Zero=1.
- FSM states are IDLE, MUL, DIV and FIN.
- Start sampled at edge N in IDLE:
  - Single-cycle op: after edge N, ALUResult and Zero (ALUResult==0) are updated and Done=1 for one cycle. FSM stays in IDLE, so back-to-back Starts are legal.
  - MULT/MULTU: go to MUL. Shift-add runs on a 2*WIDTH accumulator.
  - DIV/DIVU: go to DIV. Restoring division runs one quotient bit per cycle.
- Iterative timing:
  - Busy=1 after edges N..N+WIDTH-1.
  - After edge N+WIDTH: Hi/Lo are written, Done=1 for one cycle, Busy=0, FSM returns to IDLE via FIN.
  - Latency is WIDTH cycles.
  - Zero reflects Lo==0 on completion.
  - ALUResult is unchanged by mult/div.
- Signed handling:
  - Operands are converted to magnitudes before iterating.
  - Product is negated if the operand signs differ.
  - Quotient sign = sign(A) xor sign(B); remainder takes the sign of the dividend.
  - Most-negative / -1 gives Lo=most-negative and Hi=0. No trap.
- Divide by zero (Operand2=0 on DIV/DIVU):
  - No iteration, Busy stays 0.
  - After edge N: Hi=Operand1, Lo=all ones, DivByZero=1, Done=1.
  - DivByZero holds until the next accepted Start, which clears it.
- Start while Busy=1 is ignored; there is no queueing.
- Operand or ALUControl changes during Busy have no effect.
- Done and Busy are never high in the same cycle.

Optional Feature:
- Macro: MULDIV_FAST_MUL_EN.
- Defined: MULT/MULTU complete in one cycle with a combinational WIDTHxWIDTH multiplier. Done follows after edge N, Busy stays 0, and the MUL state is unused.
- Undefined: iterative multiply with WIDTH-cycle latency as above.
- Divide is unaffected in both cases.

Test Plan:
- Reset: hold reset 2 cycles with Start=1 -> all outputs 0, Busy=0, no Done.
- ADD 85+16554 -> ALUResult=16639, Zero=0, Done after 1 cycle.
  - SUB 85-85 -> ALUResult=0, Zero=1.
  - SUB 0-1 -> ALUResult=0xFFFFFFFF.
  - SLT 0xFFFFFFFF,1 -> 1; SLTU 0xFFFFFFFF,1 -> 0.
- MULT -3*7 -> Busy 32 cycles, then Done, Hi=0xFFFFFFFF, Lo=0xFFFFFFEB.
  - MULTU 0xFFFFFFFF*0xFFFFFFFF -> Hi=0xFFFFFFFE, Lo=0x00000001.
  - MFLO afterwards -> ALUResult=0x00000001.
- DIV -7/2 -> Lo=0xFFFFFFFD, Hi=0xFFFFFFFF.
  - DIVU 100/7 -> Lo=14, Hi=2.
  - DIV 0x80000000/0xFFFFFFFF -> Lo=0x80000000, Hi=0.
- DIVU 5/0 -> Done after 1 cycle, Busy never 1, DivByZero=1, Hi=5, Lo=0xFFFFFFFF.
  - Next ADD Start clears DivByZero.
- Start ADD at cycle 5 of a DIV -> ignored, DIV result correct.
  - Reset at cycle 10 of a DIV -> Busy=0, Hi=Lo=0, no Done pulse.
